countdown_scheduler: RTL and testbench
======================================

// Module: countdown_scheduler
// PURPOSE
//   Shares one CNT_W-bit down-counter among NUM_REQ requesters. Arbitrates round-robin,
//   loads the winner's count, decrements on each tick, and pulses done to the owner at zero.
//   Sits between timer clients and the counter datapath; sequences one countdown at a time.
// PARAMETERS
//   NUM_REQ  4  number of requesters (>=2)
//   CNT_W    4  counter width in bits
//   IDX_W    $clog2(NUM_REQ)  owner index width (derived, not overridden)
// PORTS
//   clk        in   1              clock, all logic on posedge
//   rst        in   1              synchronous reset, active-high
//   req_valid  in   NUM_REQ        per-requester countdown request
//   req_cnt    in   NUM_REQ*CNT_W  start count, requester i at [i*CNT_W +: CNT_W]
//   req_ready  out  NUM_REQ        one-hot accept; handshake = req_valid[i] & req_ready[i]
//   tick       in   1              decrement enable (counter ena)
//   abort      in   1              cancel the active countdown
//   done       out  NUM_REQ        one-cycle completion pulse to owner
//   busy       out  1              countdown in progress (state != IDLE)
//   owner      out  IDX_W          index of current/last granted requester
//   cnt        out  CNT_W          current counter value
// BEHAVIOUR
//   Reset: state IDLE, cnt = all ones, owner = 0, rr_ptr = 0; done = 0, busy = 0.
//     req_ready = 0 while rst is high. Reset mid-countdown drops it; no done pulse.
//   States: IDLE -> COUNT -> DONE -> IDLE; COUNT -> IDLE on abort.
//   IDLE: req_ready is combinational. It is one-hot on the first i with req_valid[i] high,
//     searching from rr_ptr upward modulo NUM_REQ. It is all-zero when no requester is valid.
//     On handshake: cnt <= req_cnt[i], owner <= i, next state COUNT.
//     abort and tick are ignored in IDLE.
//   COUNT: priority order is abort > zero-detect > tick.
//     abort: next IDLE, no done, rr_ptr <= owner+1 mod NUM_REQ, cnt holds.
//     cnt == 0: next DONE, regardless of tick.
//     tick with cnt != 0: cnt <= cnt - 1. No tick: cnt holds.
//     cnt never wraps below zero.
//   DONE: done[owner] = 1 for exactly this cycle, all other done bits 0.
//     rr_ptr <= owner+1 mod NUM_REQ, next IDLE. cnt stays 0.
//   Latency with tick held high:
//     handshake at cycle 0, cnt = K at cycle 1, done at cycle K+2.
//     K = 0 gives done at cycle 2. Earliest next handshake is cycle K+3.
//   req_ready is 0 in COUNT and DONE. A requester holds req_valid and req_cnt until accepted.
//     Deasserting before acceptance is legal; the request is simply not seen.
//   done, busy, owner and cnt are decoded from flops only; no combinational path from inputs.
//   Fairness: a continuously valid requester is granted within NUM_REQ grants.
// TESTING
//   1 Reset: rst for 2 cycles -> busy=0, done=0, cnt=4'hf, owner=0, req_ready=0 during rst.
//   2 Single request: req_valid=4'b0100, req_cnt[2]=3, tick=1 -> req_ready=4'b0100 at cycle 0;
//     cnt 3,2,1,0 on cycles 1-4; done=4'b0100 at cycle 5 only; busy low at cycle 6.
//   3 Round-robin: all four valid, each req_cnt=0, tick=1 -> grants in order 0,1,2,3,0.
//     Each done arrives 2 cycles after its grant; no requester is granted twice in a row.
//   4 Tick gating: req_cnt=2, tick toggling 1,0,0,1 -> cnt holds while tick=0; done delayed by 2 cycles.
//   5 Abort: abort at cycle 2 of a K=5 countdown (owner=1) -> IDLE next cycle, no done.
//     Next grant goes to requester 2 if valid. Abort while cnt==0 also suppresses done.
//   6 Reset mid-count: rst asserted at cnt=2 -> no done pulse, state IDLE, cnt=4'hf, rr_ptr=0.

Source files
------------

// File: rtl/countdown_scheduler.sv
// Round-robin scheduler that lends a single down-counter to one requester at a time
// and pulses that requester's done bit when its countdown reaches zero.
module countdown_scheduler #(
    parameter int  NUM_REQ = 4,
    parameter int  CNT_W   = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*CNT_W-1:0] req_cnt,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     tick,
    input  logic                     abort,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [IDX_W-1:0]         owner,
    output logic [CNT_W-1:0]         cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [IDX_W:0] NUM_REQ_X = (IDX_W+1)'(NUM_REQ);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             handshake;
    logic [IDX_W:0]   probe;
    logic [IDX_W:0]   owner_inc;
    logic [IDX_W-1:0] next_ptr;

    // Search from rr_ptr upward, wrapping at NUM_REQ, for the first valid requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        probe     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            probe = {1'b0, rr_ptr} + (IDX_W+1)'(off);
            if (probe >= NUM_REQ_X) begin
                probe = probe - NUM_REQ_X;
            end
            if (!grant_any && req_valid[probe[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = probe[IDX_W-1:0];
            end
        end
    end

    assign handshake = (state == S_IDLE) && !rst && grant_any;

    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        owner_inc = {1'b0, owner} + 1'b1;
        if (owner_inc == NUM_REQ_X) begin
            owner_inc = '0;
        end
        next_ptr = owner_inc[IDX_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort outranks zero-detect so a cancelled countdown never reaches DONE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant_any) begin
                    state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (cnt == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '1;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        cnt   <= req_cnt[int'(grant_idx)*CNT_W +: CNT_W];
                        owner <= grant_idx;
                    end
                end
                S_COUNT: begin
                    if (abort) begin
                        rr_ptr <= next_ptr;
                    end else if ((cnt != '0) && tick) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    rr_ptr <= next_ptr;
                end
                default: begin
                    rr_ptr <= rr_ptr;
                end
            endcase
        end
    end

    always_comb begin
        done = '0;
        if (state == S_DONE) begin
            done[owner] = 1'b1;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_countdown_scheduler.sv
// Directed bench for countdown_scheduler: stimulus queues expected grant/done events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_countdown_scheduler;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*CNT_W-1:0] req_cnt;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     tick;
    logic                     abort;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [IDX_W-1:0]         owner;
    logic [CNT_W-1:0]         cnt;

    typedef struct {
        int idx;
        int cyc;
    } ev_t;

    ev_t grant_q[$];
    ev_t done_q[$];
    ev_t ge;
    ev_t de;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    int c;
    int d;
    logic [NUM_REQ-1:0] hs;
    logic [NUM_REQ-1:0] exp_v;

    int t4_tick[6] = '{1, 1, 0, 0, 1, 1};
    int t4_cnt[6]  = '{0, 2, 1, 1, 1, 0};

    countdown_scheduler #(
        .NUM_REQ (NUM_REQ),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_cnt   (req_cnt),
        .req_ready (req_ready),
        .tick      (tick),
        .abort     (abort),
        .done      (done),
        .busy      (busy),
        .owner     (owner),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] v,
                                 input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1,
                                 input logic [CNT_W-1:0] c2, input logic [CNT_W-1:0] c3,
                                 input logic t, input logic a);
        req_valid = v;
        req_cnt   = {c3, c2, c1, c0};
        tick      = t;
        abort     = a;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pulseReset(input int n);
        rst = 1'b1;
        repeat (n) next_cycle();
        rst = 1'b0;
    endtask

    // Every handshake and every done pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (mon_en) begin
            hs = req_valid & req_ready;
            if (hs != '0) begin
                n_cmp++;
                if (grant_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_grant: got %b at cycle %0d, expected none", hs, cyc);
                end else begin
                    ge    = grant_q.pop_front();
                    exp_v = NUM_REQ'(1) << ge.idx;
                    if (hs !== exp_v || cyc != ge.cyc) begin
                        n_fail++;
                        $display("[TB] FAIL grant: got %b at cycle %0d, expected %b at cycle %0d",
                                 hs, cyc, exp_v, ge.cyc);
                    end
                end
            end
            if (done != '0) begin
                n_cmp++;
                if (done_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_done: got %b at cycle %0d, expected none", done, cyc);
                end else begin
                    de    = done_q.pop_front();
                    exp_v = NUM_REQ'(1) << de.idx;
                    if (done !== exp_v || cyc != de.cyc) begin
                        n_fail++;
                        $display("[TB] FAIL done: got %b at cycle %0d, expected %b at cycle %0d",
                                 done, cyc, exp_v, de.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        // Reset with every requester valid: no grant may leak out during reset.
        rst = 1'b1;
        applyStimulus(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b0);
        next_cycle();
        @(negedge clk);
        checkOutput("t1_ready_in_rst", req_ready, 4'b0000);
        next_cycle();
        @(negedge clk);
        checkOutput("t1_ready_in_rst2", req_ready, 4'b0000);
        checkOutput("t1_busy", busy, 0);
        checkOutput("t1_done", done, 4'b0000);
        checkOutput("t1_cnt", cnt, 4'hf);
        checkOutput("t1_owner", owner, 0);
        next_cycle();
        rst = 1'b0;
        applyStimulus(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        mon_en = 1'b1;

        // Single request, K=3, tick held high.
        next_cycle();
        c = cyc;
        applyStimulus(4'b0100, 4'h0, 4'h0, 4'h3, 4'h0, 1'b1, 1'b0);
        grant_q.push_back('{2, c});
        done_q.push_back('{2, c + 5});
        @(negedge clk);
        checkOutput("t2_ready", req_ready, 4'b0100);
        next_cycle();
        applyStimulus(4'b0000, 4'h0, 4'h0, 4'h3, 4'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t2_cnt", cnt, 3 - k);
            checkOutput("t2_busy_cnt", busy, 1);
            next_cycle();
        end
        @(negedge clk);
        checkOutput("t2_busy_done", busy, 1);
        checkOutput("t2_owner", owner, 2);
        next_cycle();
        @(negedge clk);
        checkOutput("t2_busy_idle", busy, 0);
        checkOutput("t2_cnt_after", cnt, 0);

        // Round-robin from a fresh pointer, all four valid with zero counts.
        next_cycle();
        pulseReset(1);
        next_cycle();
        c = cyc;
        applyStimulus(4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            grant_q.push_back('{i % 4, c + 3 * i});
            done_q.push_back('{i % 4, c + 3 * i + 2});
        end
        repeat (13) next_cycle();
        applyStimulus(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t3_owner", owner, 0);
        next_cycle();
        next_cycle();

        // Tick gating: two idle ticks stretch a K=2 countdown by two cycles.
        next_cycle();
        c = cyc;
        applyStimulus(4'b1000, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0);
        grant_q.push_back('{3, c});
        done_q.push_back('{3, c + 6});
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            applyStimulus(4'b0000, 4'h0, 4'h0, 4'h0, 4'h2, t4_tick[k][0], 1'b0);
            @(negedge clk);
            checkOutput("t4_cnt", cnt, t4_cnt[k]);
        end
        next_cycle();
        next_cycle();

        // Abort mid-count hands the next grant to owner+1.
        next_cycle();
        c = cyc;
        applyStimulus(4'b0010, 4'h0, 4'h5, 4'h0, 4'h0, 1'b1, 1'b0);
        grant_q.push_back('{1, c});
        next_cycle();
        applyStimulus(4'b0000, 4'h0, 4'h5, 4'h0, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t5_cnt_load", cnt, 5);
        next_cycle();
        applyStimulus(4'b0000, 4'h0, 4'h5, 4'h0, 4'h0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("t5_cnt_abort", cnt, 4);
        next_cycle();
        d = cyc;
        applyStimulus(4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        grant_q.push_back('{2, d});
        @(negedge clk);
        checkOutput("t5_busy_after_abort", busy, 0);
        checkOutput("t5_cnt_hold", cnt, 4);
        checkOutput("t5_ready_next", req_ready, 4'b0100);
        next_cycle();
        applyStimulus(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("t5_cnt_zero", cnt, 0);
        next_cycle();
        applyStimulus(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t5_busy_zero_abort", busy, 0);
        checkOutput("t5_done_zero_abort", done, 4'b0000);
        next_cycle();
        next_cycle();

        // Reset while cnt=2 drops the countdown and clears the pointer.
        next_cycle();
        c = cyc;
        applyStimulus(4'b0001, 4'h4, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        grant_q.push_back('{0, c});
        next_cycle();
        applyStimulus(4'b0000, 4'h4, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        checkOutput("t6_cnt_before", cnt, 2);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_ready_in_rst", req_ready, 4'b0000);
        next_cycle();
        @(negedge clk);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_cnt", cnt, 4'hf);
        checkOutput("t6_owner", owner, 0);
        next_cycle();
        rst = 1'b0;
        c = cyc;
        applyStimulus(4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        grant_q.push_back('{0, c});
        done_q.push_back('{0, c + 2});
        next_cycle();
        applyStimulus(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        repeat (4) next_cycle();

        checkOutput("grant_q_drained", grant_q.size(), 0);
        checkOutput("done_q_drained", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
